// File: rtl/cdc_tx_sched.sv
// Source-domain scheduler for a shared slow CDC channel: round-robin grant, then
// sequences data/enable so the word is stable across setup, enable pulse and recovery gap.
module cdc_tx_sched #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned HOLD_CYC  = 3,
    parameter int unsigned GAP_CYC   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      data_in,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [DW-1:0]            data_out,
    output logic                     data_en,
    output logic                     busy
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned MaxAb = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned CntMax = (MaxAb > GAP_CYC) ? MaxAb : GAP_CYC;
    localparam int unsigned CW = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StHold, StGap} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   ptr_q;

    logic [DW-1:0]   words [N_REQ];
    logic            win_valid;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   ptr_next;

    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign words[i] = data_in[i*DW +: DW];
    end

    // First set request scanning upward from the pointer, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = IW'((32'(ptr_q) + i) % N_REQ);
            if (!win_valid && req[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign ptr_next = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= '0;
            ack      <= '0;
            grant_id <= '0;
            data_out <= '0;
            data_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        ack      <= N_REQ'(1) << win_idx;
                        grant_id <= win_idx;
                        data_out <= words[win_idx];
                        busy     <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == CW'(SETUP_CYC - 1)) begin
                        data_en <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == CW'(HOLD_CYC - 1)) begin
                        data_en <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == CW'(GAP_CYC - 1)) begin
                        busy    <= 1'b0;
                        ptr_q   <= ptr_next;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
